// File: rtl/hbc_ctrl_mc.sv
// hbc_ctrl_mc: HyperBus controller bridging a 32-bit valid/ready port to up to
// NUM_CS devices, one 32-bit word per transaction.
module hbc_ctrl_mc #(
  parameter int unsigned NUM_CS        = 2,
  parameter int unsigned CS_ADDR_LSB   = 23,
  parameter int unsigned LATENCY       = 6,
  parameter int unsigned FIXED_LATENCY = 1,
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned CSHI_CYCLES   = 2,
  parameter int unsigned RD_TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cfg_access,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic [3:0]        i_mem_wstrb,
  input  logic [31:0]       i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  output logic [31:0]       o_mem_rdata,
  output logic              o_mem_err,
  output logic [NUM_CS-1:0] o_csn,
  output logic              o_clk,
  output logic              o_clkn,
  output logic [7:0]        o_dq,
  input  logic [7:0]        i_dq,
  output logic              o_dq_de,
  output logic              o_rwds,
  input  logic              i_rwds,
  output logic              o_rwds_de,
  output logic              o_resetn
);

  localparam int unsigned CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_END, S_CSHI
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q;
  logic [1:0]        bidx_q;
  logic [31:1]       addr_q;
  logic [31:0]       wdata_q, rbuf_q, rbuf_n, rdata_q;
  logic [3:0]        wstrb_q;
  logic              cfg_q, dbl_q, clk_q, resetn_q, err_q;
  logic              rwds_q, rwds_p;
  logic [7:0]        dq_q, ca_byte, wr_byte;
  logic              wr_mask;
  logic [NUM_CS-1:0] csel_q, csel_d;
  logic [CSW-1:0]    cs_idx;
  logic              cs_hit, is_rd, active_q, active_d, rd_cap, rd_tmo;
  logic [15:0]       lat_last;
  logic [1:0]        wr_last;
  logic [47:0]       ca_w;
  logic              unused_addr0;

  assign unused_addr0 = i_mem_addr[0];

  // Chip-select decode; an out-of-range index leaves every select inactive
  always_comb begin
    cs_idx = (NUM_CS > 1) ? i_mem_addr[CS_ADDR_LSB +: CSW] : '0;
    csel_d = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) csel_d[i] = (cs_idx == CSW'(i));
  end
  assign cs_hit = |csel_d;

  assign is_rd    = (wstrb_q == 4'd0);
  assign active_q = state_q inside {S_CA, S_LAT, S_WDATA, S_RDATA};
  assign active_d = state_d inside {S_CA, S_LAT, S_WDATA, S_RDATA};
  assign lat_last = dbl_q ? 16'(4 * LATENCY - 1) : 16'(2 * LATENCY - 1);
  assign wr_last  = cfg_q ? 2'd1 : 2'd3;
  assign rd_cap   = (state_q == S_RDATA) && (rwds_q != rwds_p);
  assign rd_tmo   = (state_q == S_RDATA) && !rd_cap && (cnt_q == 16'(RD_TIMEOUT - 1));
  assign ca_w     = {is_rd, cfg_q, 1'b1, addr_q[31:3], 13'd0, 1'b0, addr_q[2:1]};

  // Byte lane selection: CA bytes MSB first, data bytes in [15:8],[7:0],[31:24],[23:16] order
  always_comb begin
    ca_byte = 8'h00;
    case (cnt_q[2:0])
      3'd0:    ca_byte = ca_w[47:40];
      3'd1:    ca_byte = ca_w[39:32];
      3'd2:    ca_byte = ca_w[31:24];
      3'd3:    ca_byte = ca_w[23:16];
      3'd4:    ca_byte = ca_w[15:8];
      3'd5:    ca_byte = ca_w[7:0];
      default: ca_byte = 8'h00;
    endcase
    rbuf_n = rbuf_q;
    case (bidx_q)
      2'd0: begin wr_byte = wdata_q[15:8];  wr_mask = ~wstrb_q[1]; rbuf_n[15:8]  = dq_q; end
      2'd1: begin wr_byte = wdata_q[7:0];   wr_mask = ~wstrb_q[0]; rbuf_n[7:0]   = dq_q; end
      2'd2: begin wr_byte = wdata_q[31:24]; wr_mask = ~wstrb_q[3]; rbuf_n[31:24] = dq_q; end
      default: begin wr_byte = wdata_q[23:16]; wr_mask = ~wstrb_q[2]; rbuf_n[23:16] = dq_q; end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   if (cnt_q == 16'(RST_CYCLES - 1)) state_d = S_IDLE;
      S_IDLE:  if (i_mem_valid) state_d = cs_hit ? S_CA : S_END;
      S_CA:    if (cnt_q == 16'd5) state_d = (cfg_q && !is_rd) ? S_WDATA : S_LAT;
      S_LAT:   if (cnt_q == lat_last) state_d = is_rd ? S_RDATA : S_WDATA;
      S_WDATA: if (bidx_q == wr_last) state_d = S_END;
      S_RDATA: if ((rd_cap && bidx_q == 2'd3) || rd_tmo) state_d = S_END;
      S_END:   state_d = (CSHI_CYCLES == 0) ? S_IDLE : S_CSHI;
      S_CSHI:  if (cnt_q == 16'(CSHI_CYCLES - 1)) state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_RST;
    else         state_q <= state_d;
  end

  // Datapath: counters, request latch, CK generation, read capture
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q    <= '0;
      bidx_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cfg_q    <= 1'b0;
      csel_q   <= '0;
      dbl_q    <= 1'b0;
      clk_q    <= 1'b0;
      resetn_q <= 1'b0;
      rwds_q   <= 1'b0;
      rwds_p   <= 1'b0;
      dq_q     <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rwds_q <= i_rwds;
      rwds_p <= rwds_q;
      dq_q   <= i_dq;
      clk_q  <= (active_q && active_d) ? ~clk_q : 1'b0;
      // The per-byte read timeout shares cnt_q; a capture reloads it
      if (state_d != state_q || rd_cap) cnt_q <= '0;
      else                              cnt_q <= cnt_q + 16'd1;
      if (state_d != state_q)                    bidx_q <= '0;
      else if (state_q == S_WDATA || rd_cap)     bidx_q <= bidx_q + 2'd1;
      if (state_q == S_RST && state_d == S_IDLE) resetn_q <= 1'b1;
      if (state_q == S_IDLE && i_mem_valid) begin
        addr_q  <= i_mem_addr[31:1];
        wdata_q <= i_mem_wdata;
        wstrb_q <= i_mem_wstrb;
        cfg_q   <= i_cfg_access;
        csel_q  <= csel_d;
      end
      if (state_q == S_CA && cnt_q == 16'd2) dbl_q <= (FIXED_LATENCY != 0) || i_rwds;
      if (rd_cap) rbuf_q <= rbuf_n;
      if (state_q == S_RDATA && state_d == S_END) begin
        if (rd_cap) begin
          rdata_q <= rbuf_n;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= '1;
          err_q   <= 1'b1;
        end
      end else if (state_d == S_END && state_q != S_END) begin
        err_q <= 1'b0;
      end
    end
  end

  // Bus-side outputs decoded from the current state
  always_comb begin
    o_csn     = '1;
    o_dq      = '0;
    o_dq_de   = 1'b0;
    o_rwds    = 1'b0;
    o_rwds_de = 1'b0;
    if (active_q) o_csn = ~csel_q;
    if (state_q == S_CA) begin
      o_dq_de = 1'b1;
      o_dq    = ca_byte;
    end else if (state_q == S_WDATA) begin
      o_dq_de = 1'b1;
      o_dq    = wr_byte;
      if (!cfg_q) begin
        o_rwds_de = 1'b1;
        o_rwds    = wr_mask;
      end
    end
  end

  assign o_clk       = clk_q;
  assign o_clkn      = ~clk_q;
  assign o_mem_ready = (state_q == S_END);
  assign o_mem_rdata = rdata_q;
  assign o_mem_err   = err_q;
  assign o_resetn    = resetn_q;

endmodule

// File: tb/tb_hbc_ctrl_mc.sv
// tb_hbc_ctrl_mc: directed checks of hbc_ctrl_mc (fixed-latency 2-CS instance and
// variable-latency 3-CS instance).
module tb_hbc_ctrl_mc;

  logic        clk = 1'b0, rstn = 1'b0, cfg = 1'b0, valid = 1'b0, valid_v = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [7:0]  dq_in = '0;
  logic        rwds_in = 1'b0;

  logic        ready, err, ck, ckn, dq_de, rwds, rwds_de, resetn;
  logic [31:0] rdata;
  logic [1:0]  csn;
  logic [7:0]  dq;

  logic        ready_v, err_v, ck_v, ckn_v, dq_de_v, rwds_v, rwds_de_v, resetn_v;
  logic [31:0] rdata_v;
  logic [2:0]  csn_v;
  logic [7:0]  dq_v;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  hbc_ctrl_mc #(.NUM_CS(2), .FIXED_LATENCY(1)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_cfg_access(cfg), .i_mem_valid(valid),
    .o_mem_ready(ready), .i_mem_wstrb(wstrb), .i_mem_addr(addr), .i_mem_wdata(wdata),
    .o_mem_rdata(rdata), .o_mem_err(err), .o_csn(csn), .o_clk(ck), .o_clkn(ckn),
    .o_dq(dq), .i_dq(dq_in), .o_dq_de(dq_de), .o_rwds(rwds), .i_rwds(rwds_in),
    .o_rwds_de(rwds_de), .o_resetn(resetn)
  );

  hbc_ctrl_mc #(.NUM_CS(3), .FIXED_LATENCY(0)) dut_v (
    .i_clk(clk), .i_rstn(rstn), .i_cfg_access(cfg), .i_mem_valid(valid_v),
    .o_mem_ready(ready_v), .i_mem_wstrb(wstrb), .i_mem_addr(addr), .i_mem_wdata(wdata),
    .o_mem_rdata(rdata_v), .o_mem_err(err_v), .o_csn(csn_v), .o_clk(ck_v), .o_clkn(ckn_v),
    .o_dq(dq_v), .i_dq(dq_in), .o_dq_de(dq_de_v), .o_rwds(rwds_v), .i_rwds(rwds_in),
    .o_rwds_de(rwds_de_v), .o_resetn(resetn_v)
  );

  // Wait (bounded) for any chip select of the chosen instance to go active
  task automatic wait_cs(input bit use_v, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (use_v ? (csn_v !== 3'b111) : (csn !== 2'b11)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Wait (bounded) for the ready pulse; cycles = negedges waited
  task automatic wait_ready(input bit use_v, input int max, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      if (use_v ? (ready_v === 1'b1) : (ready === 1'b1)) begin
        ok = 1'b1;
        cycles = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic quiet;
    #2;
    n_cmp++;
    if ({csn, ck, ckn, dq, dq_de, rwds, rwds_de, ready, err, resetn} !== 18'b11_0_1_00000000_0_0_0_0_0_0) begin
      n_bad++;
      $display("FAIL reset_outputs got %b exp %b",
               {csn, ck, ckn, dq, dq_de, rwds, rwds_de, ready, err, resetn}, 18'b11_0_1_00000000_0_0_0_0_0_0);
    end
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    quiet = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 10) begin
        addr = 32'h0000_0010; wdata = 32'hAABB_CCDD; wstrb = 4'b0101; cfg = 1'b0; valid = 1'b1;
      end
      if (ready !== 1'b0 || csn !== 2'b11) quiet = 1'b0;
      if (k == 63) begin
        n_cmp++;
        if (resetn !== 1'b0) begin n_bad++; $display("FAIL resetn_c63 got %b exp 0", resetn); end
      end
      if (k == 64) begin
        n_cmp++;
        if (resetn !== 1'b1) begin n_bad++; $display("FAIL resetn_c64 got %b exp 1", resetn); end
      end
    end
    n_cmp++;
    if (quiet !== 1'b1) begin n_bad++; $display("FAIL req_ignored_in_rst got %b exp 1", quiet); end
  endtask

  task automatic test_write();
    logic [47:0] exp_ca = 48'h2000_0002_0000;
    logic [31:0] exp_d  = 32'hCCDD_AABB;
    logic [3:0]  exp_m  = 4'b1010;
    bit ok;
    int bad_ca = 0, bad_ck = 0, bad_d = 0, lat = 0, pulses = 0;
    addr = 32'h0000_0010; wdata = 32'hAABB_CCDD; wstrb = 4'b0101; cfg = 1'b0; valid = 1'b1;
    wait_cs(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL write_start got timeout exp cs active"); end
    n_cmp++;
    if (csn !== 2'b10) begin n_bad++; $display("FAIL write_csn got %b exp 10", csn); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (dq !== exp_ca[47-8*i -: 8] || dq_de !== 1'b1) bad_ca++;
      if (ck !== ((i % 2) == 1) || ckn !== ((i % 2) == 0)) bad_ck++;
    end
    n_cmp++;
    if (bad_ca != 0) begin n_bad++; $display("FAIL write_ca got %0d bad bytes exp 0", bad_ca); end
    n_cmp++;
    if (bad_ck != 0) begin n_bad++; $display("FAIL write_ck got %0d bad cycles exp 0", bad_ck); end
    @(negedge clk);
    while (dq_de === 1'b0 && lat < 100) begin lat++; @(negedge clk); end
    n_cmp++;
    if (lat != 24) begin n_bad++; $display("FAIL write_lat got %0d exp 24", lat); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (dq !== exp_d[31-8*i -: 8] || rwds !== exp_m[3-i] || rwds_de !== 1'b1 || dq_de !== 1'b1) bad_d++;
    end
    n_cmp++;
    if (bad_d != 0) begin n_bad++; $display("FAIL write_data got %0d bad bytes exp 0", bad_d); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        pulses++;
        valid = 1'b0;
        n_cmp++;
        if (csn !== 2'b11 || ck !== 1'b0 || dq_de !== 1'b0) begin
          n_bad++; $display("FAIL write_end_idle got csn=%b ck=%b de=%b exp 11/0/0", csn, ck, dq_de);
        end
      end
    end
    valid = 1'b0;
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL write_ready_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_read();
    logic [47:0] exp_ca = 48'hA010_0000_0002;
    logic [31:0] bytes  = 32'h1122_3344;
    bit ok;
    int bad_ca = 0, cyc;
    addr = 32'h0080_0004; wstrb = 4'b0000; cfg = 1'b0; rwds_in = 1'b0; valid = 1'b1;
    wait_cs(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL read_start got timeout exp cs active"); end
    n_cmp++;
    if (csn !== 2'b01) begin n_bad++; $display("FAIL read_csn got %b exp 01", csn); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (dq !== exp_ca[47-8*i -: 8]) bad_ca++;
    end
    n_cmp++;
    if (bad_ca != 0) begin n_bad++; $display("FAIL read_ca got %0d bad bytes exp 0", bad_ca); end
    repeat (28) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dq_in   = bytes[31-8*i -: 8];
      rwds_in = ~rwds_in;
      if (i < 3) repeat (3) @(negedge clk);
    end
    wait_ready(1'b0, 20, ok, cyc);
    valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL read_ready got timeout exp pulse"); end
    n_cmp++;
    if (rdata !== 32'h3344_1122) begin n_bad++; $display("FAIL read_rdata got %h exp %h", rdata, 32'h3344_1122); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL read_err got %b exp 0", err); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_var_latency();
    bit ok;
    int lat, cyc;
    for (int pass = 0; pass < 2; pass++) begin
      addr = 32'h0000_0010; wdata = 32'h1234_5678; wstrb = 4'hF; cfg = 1'b0;
      rwds_in = (pass == 1);
      valid_v = 1'b1;
      wait_cs(1'b1, ok);
      n_cmp++;
      if (!ok || csn_v !== 3'b110) begin n_bad++; $display("FAIL var_start%0d got csn=%b exp 110", pass, csn_v); end
      repeat (5) @(negedge clk);
      rwds_in = 1'b0;
      lat = 0;
      @(negedge clk);
      while (dq_de_v === 1'b0 && lat < 100) begin lat++; @(negedge clk); end
      n_cmp++;
      if (lat != ((pass == 1) ? 24 : 12)) begin
        n_bad++; $display("FAIL var_lat%0d got %0d exp %0d", pass, lat, (pass == 1) ? 24 : 12);
      end
      wait_ready(1'b1, 20, ok, cyc);
      valid_v = 1'b0;
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL var_ready%0d got timeout exp pulse", pass); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_bad_cs();
    bit got = 1'b0, act = 1'b0;
    addr = 32'h0180_0000; wstrb = 4'hF; cfg = 1'b0; valid_v = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (csn_v !== 3'b111 || dq_de_v !== 1'b0) act = 1'b1;
      if (ready_v === 1'b1) begin got = 1'b1; break; end
    end
    valid_v = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL badcs_ready got %b exp 1", got); end
    n_cmp++;
    if (act !== 1'b0) begin n_bad++; $display("FAIL badcs_bus_activity got %b exp 0", act); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cfg_write();
    logic [47:0] exp_ca = 48'h6000_0000_0000;
    bit ok;
    int bad_ca = 0;
    addr = 32'h0; wdata = 32'h0000_8F1F; wstrb = 4'b0011; cfg = 1'b1; valid = 1'b1;
    wait_cs(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL cfg_start got timeout exp cs active"); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (dq !== exp_ca[47-8*i -: 8] || dq_de !== 1'b1) bad_ca++;
    end
    n_cmp++;
    if (bad_ca != 0) begin n_bad++; $display("FAIL cfg_ca got %0d bad bytes exp 0", bad_ca); end
    @(negedge clk);
    n_cmp++;
    if ({dq_de, dq, rwds_de} !== {1'b1, 8'h8F, 1'b0}) begin
      n_bad++; $display("FAIL cfg_byte0 got de=%b dq=%h rde=%b exp 1/8f/0", dq_de, dq, rwds_de);
    end
    @(negedge clk);
    n_cmp++;
    if ({dq_de, dq, rwds_de} !== {1'b1, 8'h1F, 1'b0}) begin
      n_bad++; $display("FAIL cfg_byte1 got de=%b dq=%h rde=%b exp 1/1f/0", dq_de, dq, rwds_de);
    end
    @(negedge clk);
    n_cmp++;
    if ({ready, dq_de} !== 2'b10) begin n_bad++; $display("FAIL cfg_end got ready=%b de=%b exp 1/0", ready, dq_de); end
    valid = 1'b0;
    cfg = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    addr = 32'h0; wstrb = 4'b0000; cfg = 1'b0; rwds_in = 1'b0; valid = 1'b1;
    wait_cs(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tmo_start got timeout exp cs active"); end
    repeat (5) @(negedge clk);
    wait_ready(1'b0, 200, ok, cyc);
    valid = 1'b0;
    n_cmp++;
    if (!ok || cyc < 88 || cyc > 92) begin n_bad++; $display("FAIL tmo_cycles got %0d exp 88..92", cyc); end
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b exp 1", err); end
    n_cmp++;
    if (rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL tmo_rdata got %h exp ffffffff", rdata); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    addr = 32'h0000_0040; wstrb = 4'b0000; cfg = 1'b0; valid = 1'b1;
    wait_cs(1'b0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rstmid_start got timeout exp cs active"); end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({csn, ck, ckn, dq, dq_de, rwds, rwds_de, ready, err, resetn} !== 18'b11_0_1_00000000_0_0_0_0_0_0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got %b exp %b",
               {csn, ck, ckn, dq, dq_de, rwds, rwds_de, ready, err, resetn}, 18'b11_0_1_00000000_0_0_0_0_0_0);
    end
    n_cmp++;
    if (rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h exp 0", rdata); end
    valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) begin
        n_cmp++;
        if (resetn !== 1'b0) begin n_bad++; $display("FAIL rerun_c63 got %b exp 0", resetn); end
      end
      if (k == 64) begin
        n_cmp++;
        if (resetn !== 1'b1) begin n_bad++; $display("FAIL rerun_c64 got %b exp 1", resetn); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_var_latency();
    test_bad_cs();
    test_cfg_write();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
